// File: rtl/mp_add_sequencer.sv
// Word-serial multi-precision adder: LS word first through one ripple-carry adder, carry kept in a register.
// Optional build macro SUBTRACT_EN enables A-B mode via the sub port (A + ~B + 1).

module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co
);
  logic [WIDTH:0] w_c;

  assign w_c[0] = i_ci;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end
  assign o_co = w_c[WIDTH];
endmodule

module mp_add_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] nwords,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             carry_out
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_remaining;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_carry_out;

  logic             w_start;
  logic             w_accept;
  logic             w_out_hs;
  logic             w_sub_mode;
  logic             w_init_carry;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_rca_sum;
  logic             w_rca_co;

`ifdef SUBTRACT_EN
  logic r_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_sub <= 1'b0;
    else if (w_start) r_sub <= sub;
  end
  assign w_sub_mode   = r_sub;
  assign w_init_carry = sub;
`else
  logic w_unused_sub;

  assign w_unused_sub = sub;
  assign w_sub_mode   = 1'b0;
  assign w_init_carry = 1'b0;
`endif

  assign w_start  = (r_state == S_IDLE) && start;
  assign w_out_hs = r_out_valid && out_ready;
  // The output register may refill in the same cycle it drains, giving one word per cycle.
  assign in_ready = (r_state == S_RUN) && (r_remaining != '0) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_b_eff  = w_sub_mode ? ~b_word : b_word;

  ripple_carry_adder #(.WIDTH(WIDTH)) u_rca (
    .i_a  (a_word),
    .i_b  (w_b_eff),
    .i_ci (r_carry),
    .o_s  (w_rca_sum),
    .o_co (w_rca_co)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (nwords != '0) ? S_RUN : S_FIN;
      S_RUN:   if (w_out_hs && r_out_last) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
    end else if (w_start) begin
      r_remaining <= nwords;
      r_carry     <= w_init_carry;
      r_carry_out <= 1'b0;
    end else if (w_accept) begin
      r_remaining <= r_remaining - CNT_W'(1);
      r_carry     <= w_rca_co;
    end else if (r_state == S_FIN) begin
      r_carry_out <= r_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_sum       <= w_rca_sum;
      r_out_valid <= 1'b1;
      r_out_last  <= (r_remaining == CNT_W'(1));
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign sum_word  = r_sum;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign carry_out = r_carry_out;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Randomized bench for mp_add_sequencer; expected words and carry come from whole-operand arithmetic.
module tb_mp_add_sequencer;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] nwords;
  logic             sub;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_word;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             carry_out;

  int n_tests = 0;
  int n_fail  = 0;

  mp_add_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .nwords    (nwords),
    .sub       (sub),
    .a_word    (a_word),
    .b_word    (b_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_word  (sum_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_in_ready"},  128'(in_ready),  128'(0));
    check_val({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check_val({tag, "_out_last"},  128'(out_last),  128'(0));
    check_val({tag, "_busy"},      128'(busy),      128'(0));
    check_val({tag, "_done"},      128'(done),      128'(0));
    check_val({tag, "_carry_out"}, 128'(carry_out), 128'(0));
    check_val({tag, "_sum_word"},  128'(sum_word),  128'(0));
  endtask

  // mode 0: continuous valid/ready, 1: random gaps and back-pressure, 2: 3-cycle stall on first output
  task automatic run_op(input int n, input bit sb, input logic [127:0] a_in,
                        input logic [127:0] b_in, input int mode);
    logic [127:0] mask, a_op, b_op, b_add;
    logic [128:0] full;
    bit           eff_sub, exp_carry, iv, ordy;
    bit           done_seen, prev_acc, prev_hold, prev_last;
    logic [7:0]   prev_sum;
    int           sent, recv, stall;

    mask = (n == 0) ? '0 : ((128'd1 << (8 * n)) - 128'd1);
    a_op = a_in & mask;
    b_op = b_in & mask;
`ifdef SUBTRACT_EN
    eff_sub = sb;
`else
    eff_sub = 1'b0;
`endif
    b_add     = eff_sub ? (~b_op & mask) : b_op;
    full      = {1'b0, a_op} + {1'b0, b_add} + 129'(eff_sub);
    exp_carry = full[8 * n];

    @(posedge clk); #1;
    start = 1'b1; nwords = 4'(n); sub = sb; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("start_busy",      128'(busy),      128'(1));
    check_val("start_carry_clr", 128'(carry_out), 128'(0));

    sent = 0; recv = 0; stall = 0;
    done_seen = 0; prev_acc = 0; prev_hold = 0; prev_last = 0; prev_sum = '0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      iv = (sent < n) && (mode == 0 || $urandom_range(0, 3) != 0);
      in_valid = iv;
      a_word   = iv ? a_op[8 * sent +: 8] : 8'($urandom);
      b_word   = iv ? b_op[8 * sent +: 8] : 8'($urandom);
      if (mode == 0)      ordy = 1'b1;
      else if (mode == 1) ordy = ($urandom_range(0, 3) != 0);
      else if (out_valid && stall < 3) begin ordy = 1'b0; stall++; end
      else                ordy = 1'b1;
      out_ready = ordy;
      @(negedge clk);
      if (prev_acc) check_val("latency_out_valid", 128'(out_valid), 128'(1));
      if (prev_hold) begin
        check_val("hold_valid", 128'(out_valid), 128'(1));
        check_val("hold_sum",   128'(sum_word),  128'(prev_sum));
        check_val("hold_last",  128'(out_last),  128'(prev_last));
      end
      check_val("in_ready", 128'(in_ready), 128'((sent < n) && (!out_valid || out_ready)));
      if (out_valid && out_ready) begin
        check_val($sformatf("sum_word%0d", recv), 128'(sum_word), 128'(full[8 * recv +: 8]));
        check_val("out_last", 128'(out_last), 128'(recv == n - 1));
        recv++;
      end
      prev_hold = out_valid && !out_ready;
      prev_sum  = sum_word;
      prev_last = out_last;
      prev_acc  = in_valid && in_ready;
      if (prev_acc) sent++;
      if (done) begin
        done_seen = 1;
        check_val("done_word_count", 128'(recv), 128'(n));
      end
      @(posedge clk); #1;
    end
    if (!done_seen) check_val("done_timeout", 128'(0), 128'(1));
    in_valid = 1'b0;
    check_val("done_one_cycle", 128'(done),      128'(0));
    check_val("end_busy",       128'(busy),      128'(0));
    check_val("end_out_valid",  128'(out_valid), 128'(0));
    check_val("carry_out",      128'(carry_out), 128'(exp_carry));
  endtask

  task automatic reset_mid_run();
    @(posedge clk); #1;
    start = 1'b1; nwords = 4'd4; sub = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; a_word = 8'hFF; b_word = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrun_reset");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_reset_done", 128'(done), 128'(0));
    check_val("post_reset_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; nwords = '0; sub = 1'b0;
    a_word = '0; b_word = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2, 1'b0, 128'h01FF, 128'h0001, 0);
    run_op(2, 1'b0, 128'hFFFF, 128'h0001, 0);
    run_op(1, 1'b1, 128'h05, 128'h07, 0);
    run_op(1, 1'b1, 128'h07, 128'h05, 0);
    run_op(3, 1'b0, 128'h123456, 128'hABCDEF, 2);
    run_op(0, 1'b0, 128'h0, 128'h0, 0);
    run_op(0, 1'b1, 128'h0, 128'h0, 0);
    run_op(15, 1'b0, '1, 128'h1, 1);

    for (int t = 0; t < 30; t++) begin
      run_op($urandom_range(0, 15), 1'($urandom_range(0, 1)),
             {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(0, 2));
    end

    reset_mid_run();
    run_op(4, 1'b0, 128'h8000_00FF, 128'h8000_0001, 1);
    run_op(3, 1'b1, 128'h00_0001, 128'h00_0002, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
